// File: rtl/udp_rx_buffer.sv
// Receive-side payload buffer for UDP: stores words of the packet being received,
// then makes the packet visible to the consumer only after its checksum result passes.
module udp_rx_buffer #(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        upper_op_st,
  input  logic        upper_op,
  input  logic        upper_op_end,
  input  logic [31:0] upper_data,
  input  logic [15:0] checksum_i,
  input  logic [15:0] crc_sum_i,
  output logic        app_valid,
  input  logic        app_ready,
  output logic [31:0] app_data,
  output logic        app_sop,
  output logic        app_eop,
  output logic [15:0] pkt_ok_cnt,
  output logic [15:0] pkt_bad_cnt,
  output logic [15:0] pkt_ovf_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   cmt_ptr_q, cmt_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [15:0]     ok_cnt_q, ok_cnt_d;
  logic [15:0]     bad_cnt_q, bad_cnt_d;
  logic [15:0]     ovf_cnt_q, ovf_cnt_d;

  logic [31:0]     data_mem [DEPTH];
  logic            sop_mem  [DEPTH];
  logic            eop_mem  [DEPTH];

  logic                  full, cmt_full, start, pass, active;
  logic                  we, wsop;
  logic [DEPTH_LOG2-1:0] waddr;
  logic                  eop_we, eop_val;
  logic [DEPTH_LOG2-1:0] eop_addr;

  // Both fullness tests use the registered read pointer, so a slot freed this cycle is reusable next cycle.
  assign full     = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
  assign cmt_full = (cmt_ptr_q - rd_ptr_q) == DEPTH_P;
  assign start    = upper_op_st & upper_op;
  assign pass     = (checksum_i == 16'h0000) | (crc_sum_i == 16'hFFFF);

  assign app_valid = rd_ptr_q != cmt_ptr_q;
  assign app_data  = data_mem[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign app_sop   = app_valid & sop_mem[rd_ptr_q[DEPTH_LOG2-1:0]];
  assign app_eop   = app_valid & eop_mem[rd_ptr_q[DEPTH_LOG2-1:0]];

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    cmt_ptr_d = cmt_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    ok_cnt_d  = ok_cnt_q;
    bad_cnt_d = bad_cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    we        = 1'b0;
    wsop      = 1'b0;
    waddr     = wr_ptr_q[DEPTH_LOG2-1:0];
    eop_we    = 1'b0;
    eop_val   = 1'b0;
    eop_addr  = wr_ptr_q[DEPTH_LOG2-1:0];
    active    = 1'b0;

    if (app_valid && app_ready) rd_ptr_d = rd_ptr_q + 1'b1;

    // A start always restarts at the commit point; in RECV that discards the unfinished packet.
    if (start) begin
      if (state_q == RECV) bad_cnt_d = bad_cnt_q + 16'd1;
      if (cmt_full) begin
        ovf_cnt_d = ovf_cnt_q + 16'd1;
        wr_ptr_d  = cmt_ptr_q;
        state_d   = DROP;
      end else begin
        we       = 1'b1;
        wsop     = 1'b1;
        waddr    = cmt_ptr_q[DEPTH_LOG2-1:0];
        wr_ptr_d = cmt_ptr_q + 1'b1;
        state_d  = RECV;
        active   = 1'b1;
      end
    end else if (state_q == RECV) begin
      active = 1'b1;
      if (upper_op) begin
        if (full) begin
          ovf_cnt_d = ovf_cnt_q + 16'd1;
          wr_ptr_d  = cmt_ptr_q;
          state_d   = DROP;
          active    = 1'b0;
        end else begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
        end
      end
    end else if (state_q == DROP && upper_op_end) begin
      state_d = IDLE;
    end

    // Freshly written words carry eop=0 so a reused slot never shows a stale end marker.
    if (we) begin
      eop_we   = 1'b1;
      eop_addr = waddr;
    end

    if (active && upper_op_end) begin
      if (pass) begin
        cmt_ptr_d = wr_ptr_d;
        ok_cnt_d  = ok_cnt_q + 16'd1;
        eop_we    = 1'b1;
        eop_val   = 1'b1;
        eop_addr  = wr_ptr_d[DEPTH_LOG2-1:0] - 1'b1;
      end else begin
        wr_ptr_d  = cmt_ptr_q;
        bad_cnt_d = bad_cnt_d + 16'd1;
      end
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rd_ptr_q  <= '0;
      cmt_ptr_q <= '0;
      wr_ptr_q  <= '0;
      ok_cnt_q  <= '0;
      bad_cnt_q <= '0;
      ovf_cnt_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all of them update from pre-edge values.
      state_q   <= state_d;
      rd_ptr_q  <= rd_ptr_d;
      cmt_ptr_q <= cmt_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      ok_cnt_q  <= ok_cnt_d;
      bad_cnt_q <= bad_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  // NOTE: storage has no reset; pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (we) begin
      data_mem[waddr] <= upper_data;
      sop_mem[waddr]  <= wsop;
    end
    if (eop_we) eop_mem[eop_addr] <= eop_val;
  end

  assign pkt_ok_cnt  = ok_cnt_q;
  assign pkt_bad_cnt = bad_cnt_q;
  assign pkt_ovf_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_udp_rx_buffer.sv
// Bench for udp_rx_buffer: packet-level reference model feeds an expected-word queue,
// a monitor pops and compares on every consumer handshake.
module tb_udp_rx_buffer;

  localparam int DL    = 2;
  localparam int DEPTH = 1 << DL;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        upper_op_st, upper_op, upper_op_end;
  logic [31:0] upper_data;
  logic [15:0] checksum_i, crc_sum_i;
  logic        app_valid, app_ready, app_sop, app_eop;
  logic [31:0] app_data;
  logic [15:0] pkt_ok_cnt, pkt_bad_cnt, pkt_ovf_cnt;

  always #5 clk = ~clk;

  udp_rx_buffer #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .rst_n(rst_n),
    .upper_op_st(upper_op_st), .upper_op(upper_op), .upper_op_end(upper_op_end),
    .upper_data(upper_data), .checksum_i(checksum_i), .crc_sum_i(crc_sum_i),
    .app_valid(app_valid), .app_ready(app_ready), .app_data(app_data),
    .app_sop(app_sop), .app_eop(app_eop),
    .pkt_ok_cnt(pkt_ok_cnt), .pkt_bad_cnt(pkt_bad_cnt), .pkt_ovf_cnt(pkt_ovf_cnt)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
  } word_t;

  word_t exp_q[$];   // words promised to the consumer, in delivery order
  word_t pend[$];    // words of the packet currently being received
  bit    in_pkt;
  int    vis;        // committed words not yet consumed
  int    m_ok, m_bad, m_ovf;
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pend.delete();
    in_pkt = 1'b0;
    vis    = 0;
    m_ok   = 0;
    m_bad  = 0;
    m_ovf  = 0;
  endtask

  // One clock of packet-level behaviour: what the buffer must do with these inputs.
  task automatic model_step(input bit st, input bit op, input bit en, input logic [31:0] d,
                            input logic [15:0] cks, input logic [15:0] crc, input bit rdy);
    int    n_commit = 0;
    bit    had_vis  = (vis > 0);
    bit    ok       = (cks == 16'h0000) || (crc == 16'hFFFF);
    word_t w;
    w.data = d;
    w.sop  = 1'b0;
    w.eop  = 1'b0;
    if (st && op) begin
      if (in_pkt) begin
        m_bad++;
        pend.delete();
      end
      if (vis >= DEPTH) begin
        m_ovf++;
        in_pkt = 1'b0;
      end else begin
        w.sop = 1'b1;
        pend.push_back(w);
        in_pkt = 1'b1;
      end
    end else if (op && in_pkt) begin
      if (vis + pend.size() >= DEPTH) begin
        m_ovf++;
        pend.delete();
        in_pkt = 1'b0;
      end else begin
        pend.push_back(w);
      end
    end
    if (en && in_pkt) begin
      if (ok) begin
        w = pend.pop_back();
        w.eop = 1'b1;
        pend.push_back(w);
        n_commit = pend.size();
        foreach (pend[i]) exp_q.push_back(pend[i]);
        m_ok++;
      end else begin
        m_bad++;
      end
      pend.delete();
      in_pkt = 1'b0;
    end
    vis = vis - ((rdy && had_vis) ? 1 : 0) + n_commit;
  endtask

  // Called at a falling edge: drive one cycle of inputs and advance to the next falling edge.
  task automatic cycle(input bit st, input bit op, input bit en, input logic [31:0] d,
                       input logic [15:0] cks, input logic [15:0] crc, input bit rdy);
    upper_op_st  = st;
    upper_op     = op;
    upper_op_end = en;
    upper_data   = d;
    checksum_i   = cks;
    crc_sum_i    = crc;
    app_ready    = rdy;
    model_step(st, op, en, d, cks, crc, rdy);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 32'h0, 16'h0, 16'h0, rdy);
  endtask

  task automatic drain(input string name);
    int budget = 40;
    while ((vis > 0 || exp_q.size() > 0) && budget > 0) begin
      idle(1, 1'b1);
      budget--;
    end
    check({name, "_left"}, exp_q.size(), 0);
    check({name, "_valid"}, app_valid, 1'b0);
  endtask

  task automatic check_counts(input string name);
    check({name, "_ok"},  pkt_ok_cnt,  16'(m_ok));
    check({name, "_bad"}, pkt_bad_cnt, 16'(m_bad));
    check({name, "_ovf"}, pkt_ovf_cnt, 16'(m_ovf));
  endtask

  initial begin : monitor
    word_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n === 1'b1 && app_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", app_valid, 1'b0);
        end else if (app_ready) begin
          e = exp_q.pop_front();
          check("out_data", app_data, e.data);
          check("out_sop",  app_sop,  e.sop);
          check("out_eop",  app_eop,  e.eop);
        end
      end
    end
  end

  initial begin : stimulus
    rst_n        = 1'b0;
    upper_op_st  = 1'b0;
    upper_op     = 1'b0;
    upper_op_end = 1'b0;
    upper_data   = '0;
    checksum_i   = '0;
    crc_sum_i    = '0;
    app_ready    = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", app_valid, 1'b0);
    check("rst_sop",   app_sop,   1'b0);
    check("rst_eop",   app_eop,   1'b0);
    check_counts("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Three-word good packet, end with the last word, crc sum passes.
    cycle(1, 1, 0, 32'h11111111, 16'h5555, 16'h0000, 1);
    cycle(0, 1, 0, 32'h22222222, 16'h5555, 16'h0000, 1);
    check("good3_not_early", app_valid, 1'b0);
    cycle(0, 1, 1, 32'h33333333, 16'h5555, 16'hFFFF, 1);
    check("good3_valid_after_end", app_valid, 1'b1);
    drain("good3");
    check("good3_ok_cnt", pkt_ok_cnt, 16'd1);

    // Same packet with a failing checksum: nothing may appear.
    cycle(1, 1, 0, 32'h11111111, 16'h1234, 16'h0000, 1);
    cycle(0, 1, 0, 32'h22222222, 16'h1234, 16'h0000, 1);
    cycle(0, 1, 1, 32'h33333333, 16'h1234, 16'hFFFE, 1);
    for (int i = 0; i < 3; i++) begin
      check("bad3_hidden", app_valid, 1'b0);
      idle(1, 1'b1);
    end
    check("bad3_bad_cnt", pkt_bad_cnt, 16'd1);

    // Single word, end one cycle later, zero checksum field.
    cycle(1, 1, 0, 32'hCAFEF00D, 16'h0000, 16'h0000, 0);
    cycle(0, 0, 1, 32'h0,        16'h0000, 16'h0000, 0);
    check("single_valid", app_valid, 1'b1);
    check("single_sop",   app_sop,   1'b1);
    check("single_eop",   app_eop,   1'b1);
    drain("single");

    // Start arriving mid-packet: first packet is dropped as bad, second delivered.
    cycle(1, 1, 0, 32'hA0A0A0A0, 16'h7777, 16'h0000, 1);
    cycle(0, 1, 0, 32'hA1A1A1A1, 16'h7777, 16'h0000, 1);
    cycle(1, 1, 0, 32'hB0B0B0B0, 16'h7777, 16'h0000, 1);
    cycle(0, 1, 1, 32'hB1B1B1B1, 16'h7777, 16'hFFFF, 1);
    drain("restart");
    check("restart_bad_cnt", pkt_bad_cnt, 16'd2);
    check_counts("restart");

    // Six-word packet into a four-word store with no consumer: overflow on word five.
    for (int i = 0; i < 6; i++)
      cycle(i == 0, 1, 0, 32'hD0000000 + i, 16'h0, 16'h0, 0);
    cycle(0, 0, 1, 32'h0, 16'h0, 16'h0, 0);
    check("ovf_hidden",  app_valid,   1'b0);
    check("ovf_ovf_cnt", pkt_ovf_cnt, 16'd1);
    cycle(1, 1, 0, 32'hE0E0E0E0, 16'h0, 16'h0, 0);
    cycle(0, 1, 1, 32'hE1E1E1E1, 16'h0, 16'h0, 0);
    check("ovf_next_valid", app_valid, 1'b1);
    drain("ovf_next");
    check_counts("ovf");

    // Two committed unread packets, then a one-cycle reset wipes everything.
    cycle(1, 1, 0, 32'hF0000001, 16'h0, 16'h0, 0);
    cycle(0, 1, 1, 32'hF0000002, 16'h0, 16'h0, 0);
    cycle(1, 1, 0, 32'hF0000003, 16'h0, 16'h0, 0);
    cycle(0, 1, 1, 32'hF0000004, 16'h0, 16'h0, 0);
    check("prerst_valid", app_valid, 1'b1);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check("postrst_valid", app_valid, 1'b0);
    check_counts("postrst");
    idle(2, 1'b1);
    check("postrst_still_empty", app_valid, 1'b0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      bit          st, op, en, rdy;
      logic [15:0] cks, crc;
      rdy = ($urandom_range(0, 99) < 60);
      if (in_pkt) begin
        st = ($urandom_range(0, 99) < 3);
        op = ($urandom_range(0, 99) < 65);
        en = ($urandom_range(0, 99) < 20);
      end else begin
        st = ($urandom_range(0, 99) < 30);
        op = st | ($urandom_range(0, 99) < 20);
        en = ($urandom_range(0, 99) < 5);
      end
      cks = ($urandom_range(0, 99) < 25) ? 16'h0000 : 16'($urandom);
      crc = ($urandom_range(0, 99) < 50) ? 16'hFFFF : 16'($urandom);
      cycle(st, op, en, $urandom, cks, crc, rdy);
      if (c % 500 == 499) check_counts("rand");
    end
    cycle(0, 0, 1, 32'h0, 16'h1111, 16'h0000, 1);
    drain("rand_end");
    check_counts("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
